// File: rtl/radix2_sdf_stage_8.sv
`default_nettype none
// ============================================================================
//  Module   : radix2_sdf_stage_8
//  Purpose  : Radix-2 single-path delay-feedback butterfly stage with an
//             8-deep delay line, driven by the phase and twiddle outputs of
//             the stage-8 twiddle ROM (32-point FFT pipeline).
//  Ports    : clk          - clock, rising edge
//             rst_n        - asynchronous reset, active low
//             in_valid_i   - din_*_i carry a valid sample this cycle
//             din_r_i/_i_i - input sample, real / imag
//             state_i      - ROM phase: 0 fill, 1 butterfly, 2 twiddle-out,
//                            3 reserved
//             w_r_i/w_i_i  - twiddle real / imag, Q.FRAC_W, used in phase 2
//             out_valid_o  - dout_*_o valid
//             dout_r_o/_i_o- registered stage output, real / imag
//  Revision : 1.0 - initial release
// ============================================================================
module radix2_sdf_stage_8 #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] din_r_i,
    input  logic [DATA_W-1:0] din_i_i,
    input  logic [1:0]        state_i,
    input  logic [DATA_W-1:0] w_r_i,
    input  logic [DATA_W-1:0] w_i_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] dout_r_o,
    output logic [DATA_W-1:0] dout_i_o
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        PH_FILL = 2'd0,
        PH_BFLY = 2'd1,
        PH_TWID = 2'd2,
        PH_RSVD = 2'd3
    } phase_e;

    phase_e w_phase;
    assign w_phase = phase_e'(state_i);

    // Delay line: index 0 is the newest entry, DEPTH-1 is the head.
    logic signed [DATA_W-1:0] dl_r_q [DEPTH];
    logic signed [DATA_W-1:0] dl_i_q [DEPTH];

    logic signed [DATA_W-1:0] dout_r_q, dout_r_d;
    logic signed [DATA_W-1:0] dout_i_q, dout_i_d;
    logic                     out_valid_q, out_valid_d;

    logic                     w_shift;
    logic signed [DATA_W-1:0] w_new_r, w_new_i;

    // Missing samples are treated as zero so the line flushes cleanly.
    logic signed [DATA_W-1:0] w_x_r, w_x_i;
    assign w_x_r = in_valid_i ? $signed(din_r_i) : '0;
    assign w_x_i = in_valid_i ? $signed(din_i_i) : '0;

    logic signed [DATA_W-1:0] w_head_r, w_head_i;
    assign w_head_r = dl_r_q[DEPTH-1];
    assign w_head_i = dl_i_q[DEPTH-1];

    // Butterfly: DATA_W-bit wrap-around add/sub, no growth.
    logic signed [DATA_W-1:0] w_sum_r, w_sum_i, w_dif_r, w_dif_i;
    assign w_sum_r = w_head_r + w_x_r;
    assign w_sum_i = w_head_i + w_x_i;
    assign w_dif_r = w_head_r - w_x_r;
    assign w_dif_i = w_head_i - w_x_i;

    // Complex multiply with full-width products. Any wrap of the 2*DATA_W
    // sum only touches bits above the kept window, so it is harmless.
    logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    assign w_p_rr = PW'(w_head_r) * PW'($signed(w_r_i));
    assign w_p_ii = PW'(w_head_i) * PW'($signed(w_i_i));
    assign w_p_ri = PW'(w_head_r) * PW'($signed(w_i_i));
    assign w_p_ir = PW'(w_head_i) * PW'($signed(w_r_i));

    // Arithmetic shift floors toward -inf; the cast keeps the low DATA_W bits.
    logic signed [DATA_W-1:0] w_prod_r, w_prod_i;
    assign w_prod_r = DATA_W'((w_p_rr - w_p_ii) >>> FRAC_W);
    assign w_prod_i = DATA_W'((w_p_ri + w_p_ir) >>> FRAC_W);

    always_comb begin
        w_shift     = 1'b0;
        w_new_r     = w_x_r;
        w_new_i     = w_x_i;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        out_valid_d = 1'b0;
        case (w_phase)
            PH_FILL: begin
                w_shift = in_valid_i;
            end
            PH_BFLY: begin
                w_shift     = 1'b1;
                w_new_r     = w_dif_r;
                w_new_i     = w_dif_i;
                dout_r_d    = w_sum_r;
                dout_i_d    = w_sum_i;
                out_valid_d = 1'b1;
            end
            PH_TWID: begin
                w_shift     = 1'b1;
                dout_r_d    = w_prod_r;
                dout_i_d    = w_prod_i;
                out_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                dl_r_q[k] <= '0;
                dl_i_q[k] <= '0;
            end
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (w_shift) begin
                dl_r_q[0] <= w_new_r;
                dl_i_q[0] <= w_new_i;
                for (int k = 1; k < DEPTH; k++) begin
                    dl_r_q[k] <= dl_r_q[k-1];
                    dl_i_q[k] <= dl_i_q[k-1];
                end
            end
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign dout_r_o    = dout_r_q;
    assign dout_i_o    = dout_i_q;

endmodule
`default_nettype wire
